associate_trainer: RTL and testbench
====================================

# associate_trainer

Sequencer that trains one `associate` unit from a small on-chip set of (argument, target) samples. It replays the set in epochs: forward pass, threshold activation, error computation, backward pass. It stops after an error-free epoch or after `EPOCHS` epochs, then runs a learning-disabled verification pass and reports convergence. It sits between the host and `associate`, masters every stream on the unit, and owns its `en` input.

## Interface
- `ARGN`, 2: arguments per sample.
- `ARGW`, 8: argument width.
- `RESW`, 16: result, target and error width.
- `DEPTH`, 4: sample store entries.
- `EPOCHS`, 25: maximum training epochs (≥1).
- `HI`, 16'h00ff: activation for non-negative result; `LO` = 16'h0000 for negative.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `smp_valid`/`smp_ready` in/out 1: sample load handshake.
- `smp_arg` in ARGN*ARGW: sample arguments.
- `smp_tgt` in RESW: sample target.
- `clear` in 1: empty the store; honoured in IDLE only.
- `start` in 1: begin run; honoured in IDLE only.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at run end.
- `converged` out 1: last verification pass had zero errors; held until next `start`.
- `epochs` out $clog2(EPOCHS+1): training epochs executed in last run.
- `en` out 1: learning enable to `associate`.
- `arg_valid`/`arg_ready` out/in 1, `arg_data` out ARGN*ARGW: forward stream.
- `res_valid`/`res_ready` in/out 1, `res_data` in RESW: result stream.
- `err_valid`/`err_ready` out/in 1, `err_data` out RESW: backward stream.
- `fbk_valid`/`fbk_ready` in/out 1, `fbk_data` in ARGN*RESW: feedback, discarded.

## Operation
- Store: DEPTH entries, write pointer `cnt`.
- `smp_ready` = (state==IDLE && cnt<DEPTH); a transfer writes entry `cnt`, then `cnt++`. When full, `smp_ready`=0.
- `clear` in IDLE sets `cnt`=0. If `clear` and `smp_valid` coincide, `clear` wins and the sample is not accepted.
- States:
  - IDLE → `start`: if `cnt`==0, go to DONE with `converged`=0 and `epochs`=0; otherwise clear `epochs`, `idx`=0, `nerr`=0, `en`=1, go to FWD.
  - FWD: `arg_valid`=1, `arg_data`=store[idx]; on handshake → RES.
  - RES: `res_ready`=1; on handshake compute `act` = `$signed(res)<0 ? LO : HI` and `err` = `tgt − act` (RESW, two's complement, wrap). If `err`≠0, `nerr++`. In training go to BWD; in verify go to NEXT.
  - BWD: `err_valid`=1, `err_data`=err; on handshake → FBK. Always issued in training, including zero error.
  - FBK: `fbk_ready`=1; on handshake → NEXT.
  - NEXT: if `idx`<`cnt`−1, `idx++` and go to FWD. Otherwise the pass is complete:
    - Training pass: `epochs++`. If `nerr`==0 or `epochs`==EPOCHS, set `en`=0 and enter verify. Otherwise start another training pass. Both cases reset `idx` and `nerr` and go to FWD.
    - Verify pass: `converged` = (`nerr`==0) → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE is ignored.
- The store is untouched by runs and is replayed by the next `start`.

## Timing
- Reset values: state IDLE, `cnt`=0, `busy`=`done`=`converged`=`en`=0, `epochs`=0, all valids and readies 0, data outputs 0.
- Every state transition is registered. All outputs are functions of registered state only, with no combinational in→out path.
- `arg_data` and `err_data` are held stable while the corresponding valid is high and ready is low.
- Minimum sample cost with ready/valid always high: 5 cycles in training (FWD, RES, BWD, FBK, NEXT) and 3 cycles in verify.
- `done` asserts the cycle after the final NEXT. `converged` and `epochs` are valid in the same cycle as `done`.
- `en` changes only in IDLE→FWD and NEXT, never while a handshake is pending.
- `rst_n` low mid-run aborts immediately to reset values and empties the store. The `associate` unit is reset by the same `rst_n`.

## Structure
- Package `associate_pkg` holds:
  - state enum `trainer_state_t` (IDLE, FWD, RES, BWD, FBK, NEXT, DONE);
  - default `HI`/`LO` constants;
  - the `act_f` threshold function.
- Sub-module `sample_store`: DEPTH×(ARGN*ARGW+RESW) register file with one write port and one async read port.

## Test plan
- AND: load {0000→0000, 00ff→0000, ff00→0000, ffff→00ff}, start → `done`, `converged`=1, `epochs`≤25, verify pass issues no `err_valid`.
- OR: targets {0000, 00ff, 00ff, 00ff} → `converged`=1.
- XOR: targets {0000, 00ff, 00ff, 0000} → `epochs`=25, `converged`=0, exactly 100 backward transfers.
- Backpressure: random 0–5 cycle stalls on `arg_ready`/`err_ready`/`res_valid`/`fbk_valid` → data stable while stalled; AND results identical to no-stall run.
- Store edges:
  - start with `cnt`=0 → `done` two cycles later, `epochs`=0, `converged`=0;
  - fifth load → `smp_ready`=0;
  - simultaneous `clear` and `smp_valid` → `cnt`=0.
- Reset mid-run: deassert `rst_n` during BWD of epoch 3 → all outputs at reset values next edge; `cnt`=0; reload and rerun AND → converges.

Source files
------------

// File: rtl/associate_pkg.sv
// Shared types and helpers for the associate trainer: sequencer states and the
// threshold activation applied to every result returned by the associate unit.
package associate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    RES,
    BWD,
    FBK,
    NEXT,
    DONE
  } trainer_state_t;

  localparam logic [15:0] ACT_HI = 16'h00ff;
  localparam logic [15:0] ACT_LO = 16'h0000;

  // Threshold on the sign of the result: negative maps to lo, otherwise hi.
  function automatic logic [15:0] act_f(input logic neg, input logic [15:0] hi,
                                        input logic [15:0] lo);
    return neg ? lo : hi;
  endfunction

endpackage

// File: rtl/sample_store.sv
// Register file holding the training samples; one write port, async read port.
// Read data follows raddr in the same cycle; writes land on the clock edge.
module sample_store #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/associate_trainer.sv
// Epoch sequencer training one associate unit from the sample store, then a verify pass.
// One registered state per stream step; every stream waits indefinitely on its partner.
module associate_trainer
  import associate_pkg::*;
#(
  parameter int              ARGN   = 2,
  parameter int              ARGW   = 8,
  parameter int              RESW   = 16,
  parameter int              DEPTH  = 4,
  parameter int              EPOCHS = 25,
  parameter logic [RESW-1:0] HI     = ACT_HI,
  parameter logic [RESW-1:0] LO     = ACT_LO
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         smp_valid,
  output logic                         smp_ready,
  input  logic [ARGN*ARGW-1:0]         smp_arg,
  input  logic [RESW-1:0]              smp_tgt,
  input  logic                         clear,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         converged,
  output logic [$clog2(EPOCHS+1)-1:0]  epochs,
  output logic                         en,
  output logic                         arg_valid,
  input  logic                         arg_ready,
  output logic [ARGN*ARGW-1:0]         arg_data,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [RESW-1:0]              res_data,
  output logic                         err_valid,
  input  logic                         err_ready,
  output logic [RESW-1:0]              err_data,
  input  logic                         fbk_valid,
  output logic                         fbk_ready,
  input  logic [ARGN*RESW-1:0]         fbk_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(EPOCHS + 1);
  localparam int DW = ARGN*ARGW + RESW;

  trainer_state_t       state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt, nerr;
  logic [AW-1:0]        idx;
  logic                 verify, wr, last, fbk_unused;
  logic [DW-1:0]        rd_word;
  logic [ARGN*ARGW-1:0] rd_arg;
  logic [RESW-1:0]      rd_tgt, err_c, err_q;

  assign wr           = smp_valid && smp_ready && !clear;
  assign {rd_tgt, rd_arg} = rd_word;
  assign last         = (CW'(idx) + CW'(1)) >= cnt;
  assign err_c        = rd_tgt - act_f(res_data[RESW-1], HI, LO);
  assign fbk_unused   = ^fbk_data;

  sample_store #(.DEPTH(DEPTH), .W(DW), .AW(AW)) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr),
    .waddr (cnt[AW-1:0]),
    .wdata ({smp_tgt, smp_arg}),
    .raddr (idx),
    .rdata (rd_word)
  );

  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE && clear) cnt_nxt = '0;
    else if (wr)                cnt_nxt = cnt + CW'(1);

    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = (cnt == '0) ? DONE : FWD;
      FWD:     if (arg_ready) state_nxt = RES;
      RES:     if (res_valid) state_nxt = verify ? NEXT : BWD;
      BWD:     if (err_ready) state_nxt = FBK;
      FBK:     if (fbk_valid) state_nxt = NEXT;
      NEXT:    state_nxt = (last && verify) ? DONE : FWD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      smp_ready <= 1'b0;
      idx       <= '0;
      nerr      <= '0;
      verify    <= 1'b0;
      en        <= 1'b0;
      converged <= 1'b0;
      epochs    <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // Registered so the load handshake has no path from start/clear.
      smp_ready <= (state_nxt == IDLE) && (cnt_nxt < CW'(DEPTH));
      case (state)
        IDLE: if (start) begin
          converged <= 1'b0;
          epochs    <= '0;
          idx       <= '0;
          nerr      <= '0;
          verify    <= 1'b0;
          if (cnt != '0) en <= 1'b1;
        end
        RES: if (res_valid) begin
          err_q <= err_c;
          if (err_c != '0) nerr <= nerr + CW'(1);
        end
        NEXT: if (!last) begin
          idx <= idx + AW'(1);
        end else begin
          idx  <= '0;
          nerr <= '0;
          if (verify) begin
            converged <= (nerr == '0);
          end else begin
            epochs <= epochs + EW'(1);
            if (nerr == '0 || (epochs + EW'(1)) == EW'(EPOCHS)) begin
              en     <= 1'b0;
              verify <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign arg_valid = (state == FWD);
  assign res_ready = (state == RES);
  assign err_valid = (state == BWD);
  assign fbk_ready = (state == FBK);
  assign arg_data  = rd_arg;
  assign err_data  = err_q;

endmodule

// File: tb/tb_associate_trainer.sv
// Directed bench: a small perceptron stands in for the associate unit; the trainer
// is run on AND/OR/XOR sets, with stalls, store edge cases and a mid-run reset.
module tb_associate_trainer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smp_valid = 1'b0, smp_ready;
  logic [15:0] smp_arg = '0, smp_tgt = '0;
  logic        clear = 1'b0, start = 1'b0;
  logic        busy, done, converged, en;
  logic [4:0]  epochs;
  logic        arg_valid, arg_ready = 1'b0;
  logic [15:0] arg_data;
  logic        res_valid = 1'b0, res_ready;
  logic [15:0] res_data = '0;
  logic        err_valid, err_ready = 1'b0;
  logic [15:0] err_data;
  logic        fbk_valid = 1'b0, fbk_ready;
  logic [31:0] fbk_data = 32'h1234_5678;

  always #5 clk = ~clk;

  associate_trainer dut (
    .clk(clk), .rst_n(rst_n),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_arg(smp_arg), .smp_tgt(smp_tgt),
    .clear(clear), .start(start), .busy(busy), .done(done), .converged(converged),
    .epochs(epochs), .en(en),
    .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .fbk_valid(fbk_valid), .fbk_ready(fbk_ready), .fbk_data(fbk_data)
  );

  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- associate stand-in: perceptron on byte-wise boolean inputs ----
  int          w0, w1, b, cur_x0, cur_x1;
  int          arg_wait, res_wait, err_wait, fbk_wait;
  int          nbwd, en_bad, unstable;
  bit          stall_en;
  bit          res_pend, fbk_pend, h_arg, h_res, h_err, h_fbk, h_err_en;
  logic [15:0] res_val, h_arg_dat, h_err_dat, prev_ad, prev_ed;
  bit          prev_av, prev_ar, prev_ev, prev_er;

  function automatic int rnd_wait();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  initial begin
    stall_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        w0 = 0; w1 = 0; b = 0;
        res_pend = 0; fbk_pend = 0;
        arg_wait = 0; res_wait = 0; err_wait = 0; fbk_wait = 0;
        h_arg = 0; h_res = 0; h_err = 0; h_fbk = 0;
        prev_av = 0; prev_ar = 0; prev_ev = 0; prev_er = 0;
        arg_ready = 0; res_valid = 0; err_ready = 0; fbk_valid = 0;
      end else begin
        if (h_arg) begin
          cur_x0   = (h_arg_dat[7:0] != 8'h00) ? 1 : 0;
          cur_x1   = (h_arg_dat[15:8] != 8'h00) ? 1 : 0;
          res_val  = 16'(w0 * cur_x0 + w1 * cur_x1 + b);
          res_pend = 1; res_wait = rnd_wait(); arg_wait = rnd_wait();
        end
        if (h_res) res_pend = 0;
        if (h_err) begin
          int s;
          s = ($signed(h_err_dat) > 0) ? 1 : (($signed(h_err_dat) < 0) ? -1 : 0);
          w0 += s * cur_x0; w1 += s * cur_x1; b += s;
          nbwd++;
          if (!h_err_en) en_bad++;
          fbk_pend = 1; fbk_wait = rnd_wait(); err_wait = rnd_wait();
        end
        if (h_fbk) fbk_pend = 0;
        // data must hold while a valid is stalled
        if (prev_av && !prev_ar && (!arg_valid || arg_data !== prev_ad)) unstable++;
        if (prev_ev && !prev_er && (!err_valid || err_data !== prev_ed)) unstable++;

        arg_ready = (arg_wait == 0);
        if (arg_valid && arg_wait > 0) arg_wait--;
        res_valid = res_pend && (res_wait == 0);
        if (res_pend && res_wait > 0) res_wait--;
        res_data  = res_val;
        err_ready = (err_wait == 0);
        if (err_valid && err_wait > 0) err_wait--;
        fbk_valid = fbk_pend && (fbk_wait == 0);
        if (fbk_pend && fbk_wait > 0) fbk_wait--;

        h_arg = arg_valid && arg_ready; h_arg_dat = arg_data;
        h_res = res_valid && res_ready;
        h_err = err_valid && err_ready; h_err_dat = err_data; h_err_en = en;
        h_fbk = fbk_valid && fbk_ready;
        prev_av = arg_valid; prev_ar = arg_ready; prev_ad = arg_data;
        prev_ev = err_valid; prev_er = err_ready; prev_ed = err_data;
      end
    end
  end

  // ---- stimulus helpers ----
  logic [15:0] sargs [4] = '{16'h0000, 16'h00ff, 16'hff00, 16'hffff};

  task automatic hard_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_one(input string nm, input logic [15:0] a, input logic [15:0] t);
    bit acc = 0;
    smp_valid = 1'b1; smp_arg = a; smp_tgt = t;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (smp_ready) acc = 1;
      @(negedge clk);
    end
    smp_valid = 1'b0;
    check({nm, ".load"}, 32'(acc), 1);
  endtask

  task automatic empty_start(input string nm);
    int cyc;
    start = 1'b1; @(negedge clk); start = 1'b0; cyc = 1;
    while (!done && cyc < 10) begin @(negedge clk); cyc++; end
    check({nm, ".done"}, 32'(done), 1);
    check({nm, ".lat"}, 32'(cyc >= 1 && cyc <= 2), 1);
    check({nm, ".epochs"}, 32'(epochs), 0);
    check({nm, ".conv"}, 32'(converged), 0);
    @(negedge clk);
    check({nm, ".idle"}, {30'd0, busy, done}, 0);
  endtask

  task automatic wait_done(input string nm, input int limit);
    int cyc = 0;
    while (!done && cyc < limit) begin @(negedge clk); cyc++; end
    check({nm, ".done_seen"}, 32'(done), 1);
  endtask

  task automatic run_case(input string nm, input logic [63:0] tg, input bit stall,
                          input int exp_ep, input bit exp_conv);
    hard_reset();
    for (int i = 0; i < 4; i++) load_one(nm, sargs[i], tg[16*i +: 16]);
    check({nm, ".full"}, 32'(smp_ready), 0);
    smp_valid = 1'b1; smp_arg = 16'h0f0f; smp_tgt = 16'h00ff;
    repeat (2) @(negedge clk);
    check({nm, ".fifth"}, 32'(smp_ready), 0);
    smp_valid = 1'b0;
    stall_en = stall; nbwd = 0; en_bad = 0; unstable = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(nm, 8000);
    check({nm, ".conv"}, 32'(converged), 32'(exp_conv));
    check({nm, ".epochs"}, 32'(epochs), 32'(exp_ep));
    check({nm, ".en_at_done"}, 32'(en), 0);
    @(negedge clk);
    check({nm, ".pulse"}, {30'd0, busy, done}, 0);
    check({nm, ".bwd"}, 32'(nbwd), 32'(exp_ep * 4));
    check({nm, ".en_bwd"}, 32'(en_bad), 0);
    check({nm, ".stable"}, 32'(unstable), 0);
    stall_en = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst.busy_done", {30'd0, busy, done}, 0);
    check("rst.conv_en", {30'd0, converged, en}, 0);
    check("rst.epochs", 32'(epochs), 0);
    check("rst.valids", {28'd0, arg_valid, err_valid, res_ready, fbk_ready}, 0);
    check("rst.smp_ready", 32'(smp_ready), 0);
    check("rst.data", {arg_data, err_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.smp_ready", 32'(smp_ready), 1);

    empty_start("empty");

    // clear wins over a coincident sample; the store is then empty
    load_one("clr", 16'h00ff, 16'h00ff);
    load_one("clr", 16'hffff, 16'h00ff);
    clear = 1'b1; smp_valid = 1'b1; smp_arg = 16'hff00; smp_tgt = 16'h00ff;
    @(negedge clk);
    clear = 1'b0; smp_valid = 1'b0;
    empty_start("clr_empty");

    run_case("and", {16'h00ff, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 6, 1'b1);
    run_case("or",  {16'h00ff, 16'h00ff, 16'h00ff, 16'h0000}, 1'b0, 4, 1'b1);
    run_case("xor", {16'h0000, 16'h00ff, 16'h00ff, 16'h0000}, 1'b0, 25, 1'b0);
    run_case("and_stall", {16'h00ff, 16'h0000, 16'h0000, 16'h0000}, 1'b1, 6, 1'b1);

    // reset during a backward transfer of epoch 3
    hard_reset();
    for (int i = 0; i < 4; i++)
      load_one("mid", sargs[i], (i == 3) ? 16'h00ff : 16'h0000);
    start = 1'b1; @(negedge clk); start = 1'b0;
    begin
      int cyc = 0;
      while (!(err_valid && epochs == 5'd2) && cyc < 3000) begin @(negedge clk); cyc++; end
    end
    check("mid.reached_bwd", 32'(err_valid && epochs == 5'd2), 1);
    rst_n = 1'b0;
    #1;
    check("mid.busy_done", {30'd0, busy, done}, 0);
    check("mid.en_conv", {30'd0, en, converged}, 0);
    check("mid.streams", {27'd0, arg_valid, err_valid, res_ready, fbk_ready, smp_ready}, 0);
    check("mid.epochs", 32'(epochs), 0);
    check("mid.data", {arg_data, err_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    empty_start("mid_empty");
    run_case("mid_and", {16'h00ff, 16'h0000, 16'h0000, 16'h0000}, 1'b0, 6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
